// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed digit scanner feeding one shared seven-segment decoder,
// with frame-synchronised value updates and a blanking gap at the start of every slot.
module sevenseg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic [3:0]          data,
  output logic [DIGITS-1:0]   an,
  output logic                pending,
  output logic                frame_done
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] staging_q, staging_d, active_q, active_d;
  logic [3:0]          data_q, data_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                pending_q, pending_d, fd_q, fd_d, en_q;
  logic                run, slot_end, frame_end;

  // en_q low on the first enabled cycle after a pause restarts the held slot from cnt=0
  always_comb begin
    run       = en && en_q;
    slot_end  = run && cnt_q == CW'(PRESCALE - 1);
    frame_end = slot_end && idx_q == IW'(DIGITS - 1);
    cnt_d     = !en ? cnt_q : (!en_q || slot_end) ? '0 : cnt_q + CW'(1);
    idx_d     = frame_end ? '0 : slot_end ? idx_q + IW'(1) : idx_q;
    staging_d = load ? value : staging_q;
    active_d  = (frame_end && load) ? value : (frame_end && pending_q) ? staging_q : active_q;
    pending_d = frame_end ? 1'b0 : (load || pending_q);
    fd_d      = frame_end;
    state_d   = (state_q == ST_BLANK) ? ((cnt_d == CW'(BLANK)) ? ST_DRIVE : ST_BLANK)
                                      : ((cnt_d == '0) ? ST_BLANK : ST_DRIVE);
    data_d    = '0;
    an_d      = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        data_d  = active_d[4*k +: 4];
        an_d[k] = !(en && state_d == ST_DRIVE && !blank_mask[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      active_q  <= '0;
      data_q    <= '0;
      an_q      <= '1;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      en_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      active_q  <= active_d;
      data_q    <= data_d;
      an_q      <= an_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
      en_q      <= en;
    end
  end

  assign data       = data_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: scoreboard bench; expected per-cycle an/data/frame_done are queued
// as stimulus is planned and popped one entry per clock edge.
module tb_sevenseg_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  data, an;
  logic        pending, frame_done;
  int          tests = 0, fails = 0;

  typedef struct packed { logic [3:0] an; logic [3:0] data; logic fd; } exp_t;
  exp_t q[$];
  exp_t e;

  sevenseg_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .blank_mask(blank_mask), .data(data), .an(an), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // one slot: 2 dark cycles then 6 lit, first n cycles of it
  function automatic void push_slot(int idx, logic [3:0] nib, bit masked, bit fd, int n);
    for (int c = 0; c < n; c++)
      q.push_back(exp_t'{an: (c < 2 || masked) ? 4'hF : ~(4'b0001 << idx), data: nib, fd: fd && c == 0});
  endfunction

  function automatic void push_frame(logic [15:0] v, logic [3:0] mask);
    for (int i = 0; i < 4; i++) push_slot(i, v[4*i +: 4], mask[i], i == 0, 8);
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      en = 1'($urandom); load = 1'($urandom); value = 16'($urandom); blank_mask = 4'($urandom);
      @(posedge clk); #1;
      tests++;
      if ({an, data, pending, frame_done} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset k=%0d got an=%b data=%h pend=%b fd=%b exp an=1111 data=0 pend=0 fd=0", k, an, data, pending, frame_done);
      end
    end
    en = 1'b1; load = 1'b0; value = '0; blank_mask = '0; rst_n = 1'b1;
    #1;
    tests++;
    if ({an, data, pending, frame_done} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_release got an=%b data=%h pend=%b fd=%b exp an=1111 data=0 pend=0 fd=0", an, data, pending, frame_done);
    end
  endtask

  task automatic test_scan();
    push_frame(16'h0, 4'h0);
    void'(q.pop_front());
    push_frame(16'h4321, 4'h0);
    for (int k = 1; k < 64; k++) begin
      load = (k == 3); value = 16'h4321;
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({an, data, frame_done} !== e) begin
        fails++;
        $display("FAIL scan k=%0d got an=%b data=%h fd=%b exp an=%b data=%h fd=%b", k, an, data, frame_done, e.an, e.data, e.fd);
      end
      tests++;
      if (pending !== (k >= 3 && k < 32)) begin
        fails++;
        $display("FAIL scan_pending k=%0d got %b exp %b", k, pending, (k >= 3 && k < 32));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_overwrite();
    push_frame(16'h4321, 4'h0);
    push_frame(16'h2222, 4'h0);
    for (int j = 0; j < 64; j++) begin
      load = (j == 3 || j == 10); value = (j == 3) ? 16'h1111 : 16'h2222;
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({an, data, frame_done} !== e) begin
        fails++;
        $display("FAIL overwrite j=%0d got an=%b data=%h fd=%b exp an=%b data=%h fd=%b", j, an, data, frame_done, e.an, e.data, e.fd);
      end
      tests++;
      if (pending !== (j >= 3 && j < 32)) begin
        fails++;
        $display("FAIL overwrite_pending j=%0d got %b exp %b", j, pending, (j >= 3 && j < 32));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_simultaneous();
    push_frame(16'hABCD, 4'h0);
    for (int j = 0; j < 32; j++) begin
      load = (j == 0); value = 16'hABCD;
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({an, data, frame_done} !== e) begin
        fails++;
        $display("FAIL simultaneous j=%0d got an=%b data=%h fd=%b exp an=%b data=%h fd=%b", j, an, data, frame_done, e.an, e.data, e.fd);
      end
      tests++;
      if (pending !== 1'b0) begin
        fails++;
        $display("FAIL simultaneous_pending j=%0d got %b exp 0", j, pending);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_mask();
    push_frame(16'hABCD, 4'b0100);
    blank_mask = 4'b0100;
    for (int j = 0; j < 32; j++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({an, data, frame_done} !== e) begin
        fails++;
        $display("FAIL mask j=%0d got an=%b data=%h fd=%b exp an=%b data=%h fd=%b", j, an, data, frame_done, e.an, e.data, e.fd);
      end
    end
    blank_mask = 4'b0000;
  endtask

  task automatic test_pause();
    push_slot(0, 4'hD, 1'b0, 1'b1, 8);
    push_slot(1, 4'hC, 1'b0, 1'b0, 6);
    for (int p = 0; p < 10; p++) q.push_back(exp_t'{an: 4'hF, data: 4'hC, fd: 1'b0});
    push_slot(1, 4'hC, 1'b0, 1'b0, 8);
    push_slot(2, 4'hB, 1'b0, 1'b0, 8);
    push_slot(3, 4'hA, 1'b0, 1'b0, 8);
    push_frame(16'hABCD, 4'h0);
    for (int j = 0; j < 80; j++) begin
      en = !(j >= 14 && j < 24);
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({an, data, frame_done} !== e) begin
        fails++;
        $display("FAIL pause j=%0d got an=%b data=%h fd=%b exp an=%b data=%h fd=%b", j, an, data, frame_done, e.an, e.data, e.fd);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_midreset();
    push_slot(0, 4'hD, 1'b0, 1'b1, 5);
    for (int j = 0; j < 5; j++) begin
      load = (j == 2); value = 16'h5555;
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({an, data, frame_done, pending} !== {e, j >= 2}) begin
        fails++;
        $display("FAIL midreset_pre j=%0d got an=%b data=%h fd=%b pend=%b exp an=%b data=%h fd=%b pend=%b", j, an, data, frame_done, pending, e.an, e.data, e.fd, j >= 2);
      end
    end
    load = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({an, data, pending, frame_done} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midreset_async got an=%b data=%h pend=%b fd=%b exp an=1111 data=0 pend=0 fd=0", an, data, pending, frame_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_frame(16'h0, 4'h0);
    void'(q.pop_front());
    push_frame(16'h0, 4'h0);
    for (int k = 1; k < 64; k++) begin
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if ({an, data, frame_done, pending} !== {e, 1'b0}) begin
        fails++;
        $display("FAIL midreset_post k=%0d got an=%b data=%h fd=%b pend=%b exp an=%b data=%h fd=%b pend=0", k, an, data, frame_done, pending, e.an, e.data, e.fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_overwrite();
    test_simultaneous();
    test_mask();
    test_pause();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
